// File: rtl/serial_frame_sched_pkg.sv
// rtl/serial_frame_sched_pkg.sv - shared state encoding and default sizing for serial_frame_sched
package serial_frame_sched_pkg;

  localparam int SFS_NUM_REQ = 2;
  localparam int SFS_FRAME_W = 40;
  localparam int SFS_CNT_W   = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/serial_frame_sched_rr_arbiter.sv
// rtl/serial_frame_sched_rr_arbiter.sv - combinational round-robin arbiter (first request at/after pointer)
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic hit;

  // Pass one covers indices at/after the pointer; pass two wraps to the ones below it.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    hit   = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!hit && req_i[j] && (j >= int'(ptr_i))) begin
        hit      = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!hit && req_i[j]) begin
        hit      = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/serial_frame_sched.sv
// rtl/serial_frame_sched.sv - round-robin shared MSB-first frame shifter
// Optional even-parity trailer bit enabled by SERIAL_FRAME_SCHED_PARITY_EN.
module serial_frame_sched
  import serial_frame_sched_pkg::*;
#(
  parameter int NUM_REQ = SFS_NUM_REQ,
  parameter int FRAME_W = SFS_FRAME_W,
  parameter int CNT_W   = SFS_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*FRAME_W-1:0] frame_i,
  input  logic                       tick_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [NUM_REQ-1:0]         done_o,
  output logic                       busy_o,
  output logic                       sd_o,
  output logic                       sd_valid_o,
  output logic [CNT_W-1:0]           bit_cnt_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

  state_e             state_q;
  logic [FRAME_W-1:0] shreg_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   ptr_d;
  logic [IDX_W-1:0]   owner_q;
  logic [NUM_REQ-1:0] win_gnt;
  logic [IDX_W-1:0]   win_idx;
  logic [FRAME_W-1:0] win_frame;
`ifdef SERIAL_FRAME_SCHED_PARITY_EN
  logic               par_q;
`endif

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx)
  );

  assign win_frame = frame_i[win_idx*FRAME_W +: FRAME_W];
  assign ptr_d     = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
`ifdef SERIAL_FRAME_SCHED_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req_i) begin
            shreg_q <= win_frame;
            owner_q <= win_idx;
            cnt_q   <= '0;
`ifdef SERIAL_FRAME_SCHED_PARITY_EN
            par_q   <= ^win_frame;
`endif
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (tick_i) begin
            if (cnt_q == LAST_BIT) begin
              cnt_q   <= '0;
`ifdef SERIAL_FRAME_SCHED_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_DONE;
`endif
            end else begin
              shreg_q <= {shreg_q[FRAME_W-2:0], 1'b0};
              cnt_q   <= cnt_q + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (tick_i) state_q <= ST_DONE;
        end
        ST_DONE: begin
          ptr_q   <= ptr_d;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Grant is live only in IDLE and suppressed while reset is asserted.
  always_comb begin
    gnt_o      = (rst_n && state_q == ST_IDLE) ? win_gnt : '0;
    done_o     = (state_q == ST_DONE) ? (NUM_REQ'(1) << owner_q) : '0;
    busy_o     = (state_q != ST_IDLE);
    sd_o       = 1'b0;
    sd_valid_o = 1'b0;
    bit_cnt_o  = '0;
    if (state_q == ST_SHIFT) begin
      sd_o       = shreg_q[FRAME_W-1];
      sd_valid_o = 1'b1;
      bit_cnt_o  = cnt_q;
    end
`ifdef SERIAL_FRAME_SCHED_PARITY_EN
    if (state_q == ST_PARITY) begin
      sd_o       = par_q;
      sd_valid_o = 1'b1;
      bit_cnt_o  = CNT_W'(FRAME_W);
    end
`endif
  end

endmodule
